// File: rtl/ifft4_pkg.sv
// Shared types and arithmetic helpers for the streaming 4-point inverse FFT.
package ifft4_pkg;

  localparam int DW = 8;
  localparam int N  = 4;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    IDLE,
    S1A,
    S1B,
    S2A,
    S2B
  } state_t;

  // (a+b)>>>1 computed one bit wider, so the result always fits in DW
  function automatic logic signed [DW-1:0] half_add(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    return s[DW:1];
  endfunction

  // (a-b)>>>1 computed one bit wider, so the result always fits in DW
  function automatic logic signed [DW-1:0] half_sub(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} - {b[DW-1], b};
    return s[DW:1];
  endfunction

endpackage

// File: rtl/ifft4_btf.sv
// Combinational radix-2 butterfly with halving: p=(a+w*b)/2, m=(a-w*b)/2, w in {1,+j}.
module ifft4_btf
  import ifft4_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  logic  tw_j,
  output cplx_t p,
  output cplx_t m
);

  // +j*b is (-b.im, b.re); folded into add/sub choice to avoid negating b
  always_comb begin
    if (tw_j) begin
      p.re = half_sub(a.re, b.im);
      p.im = half_add(a.im, b.re);
      m.re = half_add(a.re, b.im);
      m.im = half_sub(a.im, b.re);
    end else begin
      p.re = half_add(a.re, b.re);
      p.im = half_add(a.im, b.im);
      m.re = half_sub(a.re, b.re);
      m.im = half_sub(a.im, b.im);
    end
  end

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse FFT, one complex sample per cycle in and out.
// Optional start-of-frame alignment (in_sof / frame_err) with IFFT4_SOF_EN.
// Component width is ifft4_pkg::DW.
module ifft4_stream
  import ifft4_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
`ifdef IFFT4_SOF_EN
  input  logic          in_sof,
  output logic          frame_err,
`endif
  output logic          out_valid,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last
);

  logic [1:0]  cnt;
  logic        sel;
  logic [1:0]  wr_k;
  logic        frame_done;
  cplx_t       bank [2][N];
  state_t      state, state_nxt;
  cplx_t       btf_a, btf_b, btf_p, btf_m;
  logic        tw_j;
  logic        cmp_wr;
  logic [1:0]  p_idx, m_idx;
  logic        load;
  cplx_t       osr [N];
  logic [N-1:0] ovld, olst;

`ifdef IFFT4_SOF_EN
  logic sof_hit;
  assign sof_hit = in_valid & in_sof;
  assign wr_k    = sof_hit ? 2'd0 : cnt;
`else
  assign wr_k    = cnt;
`endif
  assign frame_done = in_valid && (wr_k == 2'd3);

  // Sample counter and ping-pong bank select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sel <= 1'b0;
`ifdef IFFT4_SOF_EN
      frame_err <= 1'b0;
`endif
    end else begin
      if (in_valid) begin
        cnt <= wr_k + 2'd1;
        if (frame_done) sel <= ~sel;
      end
`ifdef IFFT4_SOF_EN
      frame_err <= sof_hit && (cnt != 2'd0);
`endif
    end
  end

  // Collection writes bank[sel]; in-place compute writes bank[~sel]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned k = 0; k < N; k++)
          bank[b][k] <= '0;
    end else begin
      if (in_valid) bank[sel][wr_k] <= {in_re, in_im};
      if (cmp_wr) begin
        bank[~sel][p_idx] <= btf_p;
        bank[~sel][m_idx] <= btf_m;
      end
    end
  end

  // Compute FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Compute FSM next state; a new frame can complete exactly in S2B
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = frame_done ? S1A : IDLE;
      S1A:     state_nxt = S1B;
      S1B:     state_nxt = S2A;
      S2A:     state_nxt = S2B;
      S2B:     state_nxt = frame_done ? S1A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly operand routing and write-back per compute step.
  // S2A leaves x0 in slot 0 and x2 in slot 1 so a1/b1 survive for S2B.
  always_comb begin
    btf_a  = bank[~sel][0];
    btf_b  = bank[~sel][2];
    tw_j   = 1'b0;
    cmp_wr = 1'b0;
    p_idx  = 2'd0;
    m_idx  = 2'd2;
    load   = 1'b0;
    unique case (state)
      S1A: begin
        cmp_wr = 1'b1;
      end
      S1B: begin
        btf_a  = bank[~sel][1];
        btf_b  = bank[~sel][3];
        cmp_wr = 1'b1;
        p_idx  = 2'd1;
        m_idx  = 2'd3;
      end
      S2A: begin
        btf_a  = bank[~sel][0];
        btf_b  = bank[~sel][1];
        cmp_wr = 1'b1;
        p_idx  = 2'd0;
        m_idx  = 2'd1;
      end
      S2B: begin
        btf_a  = bank[~sel][2];
        btf_b  = bank[~sel][3];
        tw_j   = 1'b1;
        load   = 1'b1;
      end
      default: ;
    endcase
  end

  ifft4_btf u_btf (
    .a    (btf_a),
    .b    (btf_b),
    .tw_j (tw_j),
    .p    (btf_p),
    .m    (btf_m)
  );

  // Output shift register: parallel load of x0..x3, then shift in zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) osr[i] <= '0;
      ovld <= '0;
      olst <= '0;
    end else if (load) begin
      osr[0] <= bank[~sel][0];
      osr[1] <= btf_p;
      osr[2] <= bank[~sel][1];
      osr[3] <= btf_m;
      ovld   <= '1;
      olst   <= 4'b1000;
    end else begin
      for (int unsigned i = 0; i < N-1; i++) osr[i] <= osr[i+1];
      osr[N-1] <= '0;
      ovld     <= {1'b0, ovld[N-1:1]};
      olst     <= {1'b0, olst[N-1:1]};
    end
  end

  assign out_valid = ovld[0];
  assign out_last  = olst[0];
  assign out_re    = osr[0].re;
  assign out_im    = osr[0].im;

endmodule

// File: tb/tb_ifft4_stream.sv
// Self-checking bench for ifft4_stream: scoreboard of expected samples and arrival cycles.
module tb_ifft4_stream;
  import ifft4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_re, in_im;
  logic       out_valid, out_last;
  logic [7:0] out_re, out_im;
`ifdef IFFT4_SOF_EN
  logic       in_sof;
  logic       frame_err;
  int         ferr_cnt = 0;
`endif

  ifft4_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
`ifdef IFFT4_SOF_EN
    .in_sof    (in_sof),
    .frame_err (frame_err),
`endif
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    bit last;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   fr_re[4], fr_im[4];
  int   ex_re[4], ex_im[4];
  int   last_d;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid sample must match the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("out_re",   $signed(out_re), mon_e.re);
          check("out_im",   $signed(out_im), mon_e.im);
          check("out_last", {31'd0, out_last}, {31'd0, mon_e.last});
          check("out_cycle", cyc, mon_e.at);
        end
      end else begin
        check("idle_zero", {15'd0, out_last, out_re, out_im}, 0);
      end
    end
  end

`ifdef IFFT4_SOF_EN
  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;
`endif

  task automatic drive(input int re, input int im, input bit sof);
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = 8'(re);
    in_im    = 8'(im);
`ifdef IFFT4_SOF_EN
    in_sof   = sof;
`endif
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
`ifdef IFFT4_SOF_EN
    in_sof   = 1'b0;
`endif
  endtask

  // Reference: staged halving radix-2 inverse DFT on plain integers
  task automatic model();
    int a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i;
    a0r = (fr_re[0] + fr_re[2]) >>> 1;  a0i = (fr_im[0] + fr_im[2]) >>> 1;
    a1r = (fr_re[0] - fr_re[2]) >>> 1;  a1i = (fr_im[0] - fr_im[2]) >>> 1;
    b0r = (fr_re[1] + fr_re[3]) >>> 1;  b0i = (fr_im[1] + fr_im[3]) >>> 1;
    b1r = (fr_re[1] - fr_re[3]) >>> 1;  b1i = (fr_im[1] - fr_im[3]) >>> 1;
    ex_re[0] = (a0r + b0r) >>> 1;  ex_im[0] = (a0i + b0i) >>> 1;
    ex_re[2] = (a0r - b0r) >>> 1;  ex_im[2] = (a0i - b0i) >>> 1;
    ex_re[1] = (a1r - b1i) >>> 1;  ex_im[1] = (a1i + b1r) >>> 1;
    ex_re[3] = (a1r + b1i) >>> 1;  ex_im[3] = (a1i - b1r) >>> 1;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 4; k++) begin
      fr_re[k] = int'($urandom_range(255, 0)) - 128;
      fr_im[k] = int'($urandom_range(255, 0)) - 128;
    end
    model();
  endtask

  // Drive fr_* with up to max_gap idle cycles before samples 1..3; x0 due 5 cycles after X3
  task automatic send_frame(input int max_gap, input bit push, input bit sof_first);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (int'($urandom_range(max_gap, 0))) gap();
      drive(fr_re[k], fr_im[k], sof_first && (k == 0));
    end
    last_d = cyc;
    if (push)
      for (int i = 0; i < 4; i++)
        q.push_back('{re: ex_re[i], im: ex_im[i], last: (i == 3), at: last_d + 5 + i});
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
`ifdef IFFT4_SOF_EN
    in_sof   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_last",  {31'd0, out_last}, 0);
    check("rst_out_re",    $signed(out_re), 0);
    check("rst_out_im",    $signed(out_im), 0);
    rst = 1'b0;
    gap();

    // Impulse, tone, rounding frames sent back-to-back
    fr_re = '{64, 0, 0, 0};  fr_im = '{0, 0, 0, 0};
    ex_re = '{16, 16, 16, 16};  ex_im = '{0, 0, 0, 0};
    send_frame(0, 1'b1, 1'b0);
    fr_re = '{0, 64, 0, 0};  fr_im = '{0, 0, 0, 0};
    ex_re = '{16, 0, -16, 0};  ex_im = '{0, 16, 0, -16};
    send_frame(0, 1'b1, 1'b0);
    fr_re = '{-1, 0, 0, 0};  fr_im = '{0, 0, 0, 0};
    ex_re = '{-1, -1, -1, -1};  ex_im = '{0, 0, 0, 0};
    send_frame(0, 1'b1, 1'b0);
    fr_re = '{1, 0, 0, 0};  fr_im = '{0, 0, 0, 0};
    ex_re = '{0, 0, 0, 0};  ex_im = '{0, 0, 0, 0};
    send_frame(0, 1'b1, 1'b0);
    gap();
    repeat (10) gap();

    // Three random frames with continuous in_valid
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      send_frame(0, 1'b1, 1'b0);
    end
    repeat (10) gap();

    // Random gaps inside frames
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      send_frame(3, 1'b1, 1'b0);
    end
    repeat (12) gap();

    // Reset while the second frame sits in S2A and the first is being output
    rand_frame();
    send_frame(0, 1'b1, 1'b0);
    rand_frame();
    send_frame(0, 1'b0, 1'b0);
    gap();
    while (cyc < last_d + 3) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 0);
    check("rst_mid_re",    $signed(out_re), 0);
    check("rst_mid_im",    $signed(out_im), 0);
    check("rst_mid_last",  {31'd0, out_last}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) gap();
    rand_frame();
    send_frame(1, 1'b1, 1'b0);
    repeat (10) gap();

`ifdef IFFT4_SOF_EN
    // Two stray samples, then a realigned frame marked by in_sof
    ferr_cnt = 0;
    drive(11, -7, 1'b0);
    drive(-33, 5, 1'b0);
    rand_frame();
    send_frame(0, 1'b1, 1'b1);
    repeat (10) gap();
    check("frame_err_pulses", ferr_cnt, 1);
`endif

    repeat (10) gap();
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
